// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state, opcode and frame-length definitions
// for the SPI configuration register file.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  function automatic int frame_len(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_cfg_regs_if.sv
// spi_cfg_regs_if: SPI pin bundle between an external master
// and the configuration register file.
interface spi_cfg_regs_if;
  logic SCK;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCK,
    output CS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCK,
    input  CS,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchroniser plus edge flop giving
// registered level, rise and fall of an asynchronous pin.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_out;

  assign s_out = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      lvl  <= s_out;
      rise <= s_out & ~lvl;
      fall <= ~s_out & lvl;
    end
  end

endmodule

// File: rtl/spi_cfg_regs.sv
// spi_cfg_regs: SPI-addressed configuration register file, CLK domain.
// Define SPI_CFG_READBACK_EN to build read frames and the MISO shifter.
module spi_cfg_regs
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  spi_cfg_regs_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] cfg,
  output logic [NUM_REGS-1:0]        cfg_update,
  output logic                       frame_err
);

  localparam int FL = frame_len(ADDR_W, DATA_W);
  localparam int CW = $clog2(FL + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FL + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FL);
  localparam logic [CW-1:0] CNT_HDR  = CW'(1 + ADDR_W);
`ifdef SPI_CFG_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .CLK (CLK),
    .RST (RST),
    .din (spi.SCK),
    .lvl (sck_lvl),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .CLK (CLK),
    .RST (RST),
    .din (spi.CS),
    .lvl (cs_lvl),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .CLK (CLK),
    .RST (RST),
    .din (spi.MOSI),
    .lvl (mosi_lvl),
    .rise(mosi_rise),
    .fall(mosi_fall)
  );

  state_t            state;
  logic [FL-1:0]     sr;
  logic [CW-1:0]     cnt;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              addr_ok;
  logic              frame_ok;

  assign rw      = sr[FL-1];
  assign addr    = sr[DATA_W +: ADDR_W];
  assign data    = sr[DATA_W-1:0];
  assign addr_ok = {1'b0, addr} < (ADDR_W+1)'(NUM_REGS);
  assign frame_ok = (cnt == CNT_FULL) && addr_ok &&
                    (rw == OP_WRITE || RB_EN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      cfg        <= RESET_VALUES;
      cfg_update <= '0;
      frame_err  <= 1'b0;
    end else begin
      cfg_update <= '0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            sr    <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // bit is taken before a coincident CS rise ends the frame
          if (sck_rise) begin
            sr <= {sr[FL-2:0], mosi_lvl};
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          end
          if (cs_rise) state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
          if (!frame_ok) begin
            frame_err <= 1'b1;
          end else if (rw == OP_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr == ADDR_W'(i)) begin
                cfg[i*DATA_W +: DATA_W] <= data;
                cfg_update[i]           <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CFG_READBACK_EN
  logic [DATA_W-1:0] miso_sr;
  logic [DATA_W-1:0] rd_word;

  // only the header has been shifted when the read word is fetched
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sr[ADDR_W-1:0] == ADDR_W'(i))
        rd_word = cfg[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miso_sr <= '0;
    end else if (state != SHIFT) begin
      miso_sr <= '0;
    end else if (sck_fall) begin
      if (cnt == CNT_HDR && sr[ADDR_W] == OP_READ)
        miso_sr <= rd_word;
      else
        miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
    end
  end

  assign spi.MISO = miso_sr[DATA_W-1];

  logic unused_ok;
  assign unused_ok = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
  assign spi.MISO = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{sck_lvl, sck_fall, cs_lvl,
                       mosi_rise, mosi_fall};
`endif

endmodule

// File: tb/tb_spi_cfg_regs.sv
// tb_spi_cfg_regs: directed SPI frames with a pulse scoreboard
// for the SPI configuration register file.
`timescale 1ns/1ps
module tb_spi_cfg_regs;
  import spi_cfg_pkg::*;

  localparam int DW   = 24;
  localparam int AW   = 4;
  localparam int NR   = 4;
  localparam int SS   = 2;
  localparam int FL   = 1 + AW + DW;
  localparam int HALF = 8;
  localparam int LAT  = SS + 3;
  localparam logic [NR*DW-1:0] RV =
    {24'h000000, 24'h000000, 24'h000000, 24'h2312EB};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [NR*DW-1:0] cfg;
  logic [NR-1:0]    cfg_update;
  logic             frame_err;

  spi_cfg_regs_if spi ();

  spi_cfg_regs #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .NUM_REGS    (NR),
    .SYNC_STAGES (SS),
    .RESET_VALUES(RV)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .spi       (spi),
    .cfg       (cfg),
    .cfg_update(cfg_update),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NR*DW-1:0] cfg;
    logic [NR-1:0]    upd;
    logic             err;
    int               due;
  } exp_t;

  exp_t             q[$];
  logic [NR*DW-1:0] model;
  int               cyc    = 0;
  int               checks = 0;
  int               errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cfg"}, cfg, RV);
    check({tag, "_miso"}, spi.MISO, 1'b0);
    check({tag, "_upd"}, cfg_update, '0);
    check({tag, "_err"}, frame_err, 1'b0);
  endtask

  // monitor: every output pulse must match the oldest expectation
  always @(negedge CLK) begin
    if (cfg_update != '0 || frame_err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got upd=%b err=%b expected none",
                 cfg_update, frame_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_cycle", cyc, e.due);
        check("cfg_update", cfg_update, e.upd);
        check("frame_err", frame_err, e.err);
        check("cfg_at_pulse", cfg, e.cfg);
      end
    end
  end

  task automatic frame(input logic          rw,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input int            nbits,
                       input int            rst_at,
                       input logic [NR-1:0] eu,
                       input logic          ee,
                       output logic [DW-1:0] rd);
    logic [FL-1:0] w;
    exp_t          e;
    w  = {rw, a, d};
    rd = '0;
    if (eu != '0) model[a*DW +: DW] = d;
    @(negedge CLK);
    spi.CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      spi.MOSI = (i < FL) ? w[FL-1-i] : 1'b0;
      repeat (HALF) @(negedge CLK);
      if (i > AW && i < FL) rd = {rd[DW-2:0], spi.MISO};
      spi.SCK = 1'b1;
      if (i == rst_at) begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST   = 1'b0;
        model = RV;
        check_reset("midburst");
      end
      repeat (HALF) @(negedge CLK);
      spi.SCK = 1'b0;
    end
    repeat (HALF) @(negedge CLK);
    if (eu != '0 || ee) begin
      e.cfg = model;
      e.upd = eu;
      e.err = ee;
      e.due = cyc + LAT;
      q.push_back(e);
    end
    spi.CS   = 1'b1;
    spi.MOSI = 1'b0;
    repeat (4 * HALF) @(negedge CLK);
  endtask

  logic [DW-1:0] rd;

  initial begin
    spi.CS   = 1'b1;
    spi.SCK  = 1'b0;
    spi.MOSI = 1'b0;
    model    = RV;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check_reset("init");

    // write to reg1 lost to a reset after bit 10
    frame(OP_WRITE, 4'd1, 24'h111111, FL, 10, 4'b0000, 1'b0, rd);
    frame(OP_WRITE, 4'd3, 24'h0F0F0F, FL, -1, 4'b1000, 1'b0, rd);
    frame(OP_WRITE, 4'd2, 24'h00ABCD, FL, -1, 4'b0100, 1'b0, rd);
    frame(OP_WRITE, 4'd1, 24'h123456, 28, -1, 4'b0000, 1'b1, rd);
    frame(OP_WRITE, 4'd1, 24'h123456, 30, -1, 4'b0000, 1'b1, rd);
    frame(OP_WRITE, 4'd7, 24'hFFFFFF, FL, -1, 4'b0000, 1'b1, rd);
    frame(OP_WRITE, 4'd4, 24'h5A5A5A, FL, -1, 4'b0000, 1'b1, rd);
`ifdef SPI_CFG_READBACK_EN
    frame(OP_READ, 4'd0, 24'h0, FL, -1, 4'b0000, 1'b0, rd);
    check("read_reg0", rd, 24'h2312EB);
    frame(OP_READ, 4'd2, 24'h0, FL, -1, 4'b0000, 1'b0, rd);
    check("read_reg2", rd, 24'h00ABCD);
`else
    frame(OP_READ, 4'd0, 24'h0, FL, -1, 4'b0000, 1'b1, rd);
    check("read_reg0_off", rd, 24'h0);
    frame(OP_READ, 4'd2, 24'h0, FL, -1, 4'b0000, 1'b1, rd);
    check("read_reg2_off", rd, 24'h0);
`endif
    frame(OP_READ, 4'd5, 24'h0, FL, -1, 4'b0000, 1'b1, rd);
    check("read_oob", rd, 24'h0);
    frame(OP_WRITE, 4'd0, 24'h000001, FL, -1, 4'b0001, 1'b0, rd);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
    check("pending_pulses", q.size(), 0);
    check("final_cfg", cfg, model);
    check("final_miso", spi.MISO, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
